// File: rtl/cv32e40p_register_file_sb.sv
// Register file with integer/FP banks, write-port forwarding,
// per-register busy scoreboard and a sequential whole-file clear.
module cv32e40p_register_file_sb #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0,
    parameter int PULP_ZFINX = 0,
    parameter int NUM_RPORTS = 3,
    parameter int BYPASS     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_RPORTS*ADDR_WIDTH-1:0] raddr_i,
    output logic [NUM_RPORTS*DATA_WIDTH-1:0] rdata_o,
    output logic [NUM_RPORTS-1:0]            rbusy_o,
    input  logic [ADDR_WIDTH-1:0]            waddr_a_i,
    input  logic [DATA_WIDTH-1:0]            wdata_a_i,
    input  logic                             we_a_i,
    input  logic [ADDR_WIDTH-1:0]            waddr_b_i,
    input  logic [DATA_WIDTH-1:0]            wdata_b_i,
    input  logic                             we_b_i,
    input  logic                             busy_set_i,
    input  logic [ADDR_WIDTH-1:0]            busy_addr_i,
    input  logic                             clr_req_i,
    output logic                             clr_busy_o,
    output logic                             clr_done_o
);

    localparam int NUM_WORDS = 2 ** (ADDR_WIDTH - 1);
    localparam bit FP_EN = (FPU != 0) && (PULP_ZFINX == 0);
    localparam int NUM_TOT_WORDS = FP_EN ? 2 * NUM_WORDS : NUM_WORDS;
    // With the FP bank present the full address is the word index.
    localparam int IW = FP_EN ? ADDR_WIDTH : ADDR_WIDTH - 1;

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_DONE} state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic                  r_clr_busy;
    logic                  r_clr_done;
    logic [DATA_WIDTH-1:0] r_mem [NUM_TOT_WORDS];
    logic [NUM_TOT_WORDS-1:0] r_busy;

    logic          w_clearing;
    logic          w_we_a;
    logic          w_we_b;
    logic          w_bset;
    logic [IW-1:0] w_idx_a;
    logic [IW-1:0] w_idx_b;
    logic [IW-1:0] w_idx_s;

    // Integer x0 and absent-bank addresses are never writable.
    function automatic logic f_valid(input logic [ADDR_WIDTH-1:0] a);
        return (a != '0) && (FP_EN || !a[ADDR_WIDTH-1]);
    endfunction

    assign w_clearing = (r_state == S_CLEAR);
    assign w_we_a  = we_a_i && f_valid(waddr_a_i) && !w_clearing;
    assign w_we_b  = we_b_i && f_valid(waddr_b_i) && !w_clearing;
    assign w_bset  = busy_set_i && f_valid(busy_addr_i) && !w_clearing;
    assign w_idx_a = waddr_a_i[IW-1:0];
    assign w_idx_b = waddr_b_i[IW-1:0];
    assign w_idx_s = busy_addr_i[IW-1:0];

    assign clr_busy_o = r_clr_busy;
    assign clr_done_o = r_clr_done;

    // Array and scoreboard: clear walk, else B over A, busy set over clear
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_TOT_WORDS; i++) r_mem[i] <= '0;
            r_busy <= '0;
        end else if (w_clearing) begin
            r_mem[r_idx]  <= '0;
            r_busy[r_idx] <= 1'b0;
        end else begin
            if (w_we_a) begin
                r_mem[w_idx_a]  <= wdata_a_i;
                r_busy[w_idx_a] <= 1'b0;
            end
            if (w_we_b) begin
                r_mem[w_idx_b]  <= wdata_b_i;
                r_busy[w_idx_b] <= 1'b0;
            end
            if (w_bset) r_busy[w_idx_s] <= 1'b1;
        end
    end

    // Clear sequencer with registered busy/done flags
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_clr_busy <= 1'b0;
            r_clr_done <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    r_clr_done <= 1'b0;
                    if (clr_req_i) begin
                        r_state    <= S_CLEAR;
                        r_idx      <= '0;
                        r_clr_busy <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == IW'(NUM_TOT_WORDS - 1)) begin
                        r_state    <= S_DONE;
                        r_clr_busy <= 1'b0;
                        r_clr_done <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state    <= S_IDLE;
                    r_clr_done <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_clr_busy <= 1'b0;
                    r_clr_done <= 1'b0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_RPORTS; k++) begin : g_rd
        logic [ADDR_WIDTH-1:0] w_ra;
        logic                  w_in;
        logic [DATA_WIDTH-1:0] w_rd;
        logic                  w_rb;

        assign w_ra = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_in = FP_EN || !w_ra[ADDR_WIDTH-1];

        // Read mux with optional same-cycle forwarding, port B first
        always_comb begin
            w_rd = '0;
            w_rb = 1'b0;
            if (w_in) begin
                w_rd = r_mem[w_ra[IW-1:0]];
                w_rb = r_busy[w_ra[IW-1:0]];
                if (BYPASS != 0) begin
                    if (w_we_b && (waddr_b_i == w_ra)) w_rd = wdata_b_i;
                    else if (w_we_a && (waddr_a_i == w_ra)) w_rd = wdata_a_i;
                end
            end
        end

        assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = w_rd;
        assign rbusy_o[k] = w_rb;
    end

endmodule

// File: tb/tb_cv32e40p_register_file_sb.sv
// Bench: two register-file configurations driven in lockstep
// and compared against a behavioural array model.
module tb_cv32e40p_register_file_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [17:0] raddr;
    logic [95:0] rdata0, rdata1;
    logic [2:0]  rbusy0, rbusy1;
    logic [5:0]  waddr_a, waddr_b, busy_addr;
    logic [31:0] wdata_a, wdata_b;
    logic        we_a, we_b, busy_set, clr_req;
    logic        cb0, cb1, cd0, cd1;

    always #5 clk = ~clk;

    // Integer-only, forwarding on
    cv32e40p_register_file_sb #(
        .FPU(0), .PULP_ZFINX(0), .BYPASS(1)
    ) u_dut0 (
        .clk(clk), .rst(rst),
        .raddr_i(raddr), .rdata_o(rdata0), .rbusy_o(rbusy0),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .busy_set_i(busy_set), .busy_addr_i(busy_addr),
        .clr_req_i(clr_req), .clr_busy_o(cb0), .clr_done_o(cd0)
    );

    // FP bank present, forwarding off
    cv32e40p_register_file_sb #(
        .FPU(1), .PULP_ZFINX(0), .BYPASS(0)
    ) u_dut1 (
        .clk(clk), .rst(rst),
        .raddr_i(raddr), .rdata_o(rdata1), .rbusy_o(rbusy1),
        .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
        .waddr_b_i(waddr_b), .wdata_b_i(wdata_b), .we_b_i(we_b),
        .busy_set_i(busy_set), .busy_addr_i(busy_addr),
        .clr_req_i(clr_req), .clr_busy_o(cb1), .clr_done_o(cd1)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model state, one set per configuration
    logic [31:0] m_mem  [2][64];
    bit          m_busy [2][64];
    int          m_left [2];
    bit          m_done [2];
    bit          cfg_fp [2] = '{1'b0, 1'b1};
    bit          cfg_byp[2] = '{1'b1, 1'b0};
    int          cfg_n  [2] = '{32, 64};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rd(int c, int k);
        return (c == 0) ? rdata0[k*32 +: 32] : rdata1[k*32 +: 32];
    endfunction

    function automatic logic rb(int c, int k);
        return (c == 0) ? rbusy0[k] : rbusy1[k];
    endfunction

    function automatic logic [5:0] ra(int k);
        return raddr[k*6 +: 6];
    endfunction

    function automatic bit wok(int c, logic [5:0] a);
        return (a != 0) && (cfg_fp[c] || a < 32);
    endfunction

    function automatic logic [31:0] exp_rd(int c, logic [5:0] a);
        if (!cfg_fp[c] && a >= 32) return 32'h0;
        if (cfg_byp[c] && m_left[c] == 0) begin
            if (we_b && wok(c, waddr_b) && waddr_b == a) return wdata_b;
            if (we_a && wok(c, waddr_a) && waddr_a == a) return wdata_a;
        end
        return m_mem[c][a];
    endfunction

    function automatic bit exp_rb(int c, logic [5:0] a);
        if (!cfg_fp[c] && a >= 32) return 1'b0;
        return m_busy[c][a];
    endfunction

    task automatic check_outs();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rdata%0d_p%0d_a%0d", c, k, ra(k)),
                    rd(c, k), exp_rd(c, ra(k)));
                chk($sformatf("rbusy%0d_p%0d_a%0d", c, k, ra(k)),
                    32'(rb(c, k)), 32'(exp_rb(c, ra(k))));
            end
            chk($sformatf("clr_busy%0d", c),
                32'((c == 0) ? cb0 : cb1), 32'(m_left[c] > 0));
            chk($sformatf("clr_done%0d", c),
                32'((c == 0) ? cd0 : cd1), 32'(m_done[c]));
        end
    endtask

    task automatic model_step();
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) begin
                    m_mem[c][i]  = 0;
                    m_busy[c][i] = 0;
                end
                m_left[c] = 0;
                m_done[c] = 0;
            end else if (m_left[c] > 0) begin
                m_mem[c][cfg_n[c] - m_left[c]]  = 0;
                m_busy[c][cfg_n[c] - m_left[c]] = 0;
                m_left[c]--;
                if (m_left[c] == 0) m_done[c] = 1;
            end else begin
                if (we_a && wok(c, waddr_a)) begin
                    m_mem[c][waddr_a]  = wdata_a;
                    m_busy[c][waddr_a] = 0;
                end
                if (we_b && wok(c, waddr_b)) begin
                    m_mem[c][waddr_b]  = wdata_b;
                    m_busy[c][waddr_b] = 0;
                end
                if (busy_set && wok(c, busy_addr))
                    m_busy[c][busy_addr] = 1;
                if (m_done[c]) m_done[c] = 0;
                else if (clr_req) m_left[c] = cfg_n[c];
            end
        end
    endtask

    task automatic tick_check();
        @(negedge clk);
        check_outs();
    endtask

    task automatic tick_step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic cycle();
        tick_check();
        tick_step();
    endtask

    task automatic idle_in();
        we_a = 0; we_b = 0; busy_set = 0; clr_req = 0; rst = 0;
        waddr_a = 0; waddr_b = 0; busy_addr = 0;
        wdata_a = 0; wdata_b = 0;
    endtask

    task automatic sweep_zero(input string tag);
        for (int a = 0; a < 64; a += 3) begin
            idle_in();
            for (int k = 0; k < 3; k++) raddr[k*6 +: 6] = 6'(a + k);
            tick_check();
            for (int c = 0; c < 2; c++)
                for (int k = 0; k < 3; k++) begin
                    chk(tag, rd(c, k), 32'h0);
                    chk(tag, 32'(rb(c, k)), 32'h0);
                end
            tick_step();
        end
    endtask

    int n_cb0, n_cb1, n_cd0, n_cd1, n_bz;

    initial begin
        idle_in();
        raddr = 0;
        rst = 1;
        @(posedge clk);
        model_step();
        #1;
        cycle();
        idle_in();
        raddr = {6'd33, 6'd9, 6'd5};
        tick_check();
        chk("rst_rdata0", rdata0[31:0], 32'h0);
        chk("rst_rdata1", rdata1[95:64], 32'h0);
        chk("rst_rbusy", 32'({rbusy0, rbusy1}), 32'h0);
        chk("rst_clr", 32'({cb0, cd0, cb1, cd1}), 32'h0);
        tick_step();

        // same-cycle read of a write to x5
        we_a = 1; waddr_a = 5; wdata_a = 32'h1234;
        raddr = {6'd0, 6'd0, 6'd5};
        tick_check();
        chk("raw_byp", rdata0[31:0], 32'h1234);
        chk("raw_nobyp", rdata1[31:0], 32'h0);
        tick_step();
        idle_in();
        tick_check();
        chk("raw_next0", rdata0[31:0], 32'h1234);
        chk("raw_next1", rdata1[31:0], 32'h1234);
        tick_step();

        // dual write collision and x0 write
        we_a = 1; waddr_a = 7; wdata_a = 32'hAAAA;
        we_b = 1; waddr_b = 7; wdata_b = 32'h5555;
        raddr = {6'd0, 6'd0, 6'd7};
        cycle();
        idle_in();
        we_a = 1; waddr_a = 0; wdata_a = 32'hFFFF;
        tick_check();
        chk("b_wins0", rdata0[31:0], 32'h5555);
        chk("b_wins1", rdata1[31:0], 32'h5555);
        chk("x0_byp", rdata0[95:64], 32'h0);
        tick_step();
        idle_in();
        tick_check();
        chk("x0_rd0", rdata0[95:64], 32'h0);
        chk("x0_rd1", rdata1[95:64], 32'h0);
        tick_step();

        // busy window on x9
        busy_set = 1; busy_addr = 9;
        raddr = {6'd0, 6'd0, 6'd9};
        cycle();
        n_bz = 0;
        for (int i = 0; i < 6; i++) begin
            idle_in();
            if (i == 2) begin
                we_a = 1; waddr_a = 9; wdata_a = 32'h99;
            end
            tick_check();
            if (rbusy0[0] && rbusy1[0]) n_bz++;
            tick_step();
        end
        chk("busy_cycles", 32'(n_bz), 32'd3);
        busy_set = 1; busy_addr = 9;
        we_b = 1; waddr_b = 9; wdata_b = 32'h9999;
        cycle();
        idle_in();
        tick_check();
        chk("set_wr_busy", 32'({rbusy0[0], rbusy1[0]}), 32'h3);
        chk("set_wr_data", rdata1[31:0], 32'h9999);
        tick_step();

        // FP bank
        we_a = 1; waddr_a = 1; wdata_a = 32'h1111;
        cycle();
        we_a = 1; waddr_a = 6'h21; wdata_a = 32'hBEEF;
        cycle();
        idle_in();
        raddr = {6'd0, 6'd1, 6'h21};
        tick_check();
        chk("f1_fp", rdata1[31:0], 32'hBEEF);
        chk("x1_fp", rdata1[63:32], 32'h1111);
        chk("f1_nofp", rdata0[31:0], 32'h0);
        chk("x1_nofp", rdata0[63:32], 32'h1111);
        tick_step();

        // fill everything, then clear with writes during CLEAR
        for (int i = 0; i < 32; i++) begin
            we_a = 1; waddr_a = 6'(2 * i); wdata_a = $urandom;
            we_b = 1; waddr_b = 6'(2 * i + 1); wdata_b = $urandom;
            busy_set = 1; busy_addr = 6'($urandom);
            raddr = 18'($urandom);
            cycle();
        end
        idle_in();
        clr_req = 1;
        cycle();
        n_cb0 = 0; n_cb1 = 0; n_cd0 = 0; n_cd1 = 0;
        for (int i = 0; i < 80; i++) begin
            idle_in();
            raddr = 18'($urandom);
            if (i < 25) begin
                we_a = 1; waddr_a = 6'($urandom); wdata_a = $urandom;
                we_b = 1; waddr_b = 6'($urandom); wdata_b = $urandom;
                busy_set = 1; busy_addr = 6'($urandom);
                clr_req = (i == 5);
            end
            tick_check();
            n_cb0 += int'(cb0); n_cb1 += int'(cb1);
            n_cd0 += int'(cd0); n_cd1 += int'(cd1);
            tick_step();
        end
        chk("clr_len0", 32'(n_cb0), 32'd32);
        chk("clr_len1", 32'(n_cb1), 32'd64);
        chk("clr_done0", 32'(n_cd0), 32'd1);
        chk("clr_done1", 32'(n_cd1), 32'd1);
        sweep_zero("clr_zero");

        // reset in the middle of a clear
        we_a = 1; waddr_a = 3; wdata_a = 32'h3333;
        cycle();
        idle_in();
        clr_req = 1;
        cycle();
        idle_in();
        for (int i = 0; i < 10; i++) cycle();
        rst = 1;
        cycle();
        idle_in();
        n_cb0 = 0; n_cd0 = 0;
        for (int i = 0; i < 80; i++) begin
            raddr = 18'($urandom);
            tick_check();
            n_cb0 += int'(cb0) + int'(cb1);
            n_cd0 += int'(cd0) + int'(cd1);
            tick_step();
        end
        chk("abort_busy", 32'(n_cb0), 32'd0);
        chk("abort_done", 32'(n_cd0), 32'd0);
        sweep_zero("abort_zero");

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            raddr    = 18'($urandom);
            we_a     = 1'($urandom);
            waddr_a  = 6'($urandom);
            wdata_a  = $urandom;
            we_b     = 1'($urandom);
            waddr_b  = ($urandom_range(0, 3) == 0) ? waddr_a
                                                   : 6'($urandom);
            wdata_b  = $urandom;
            busy_set = 1'($urandom);
            busy_addr = ($urandom_range(0, 3) == 0) ? waddr_a
                                                    : 6'($urandom);
            if ($urandom_range(0, 1) == 0) raddr[5:0] = waddr_a;
            if ($urandom_range(0, 2) == 0) raddr[11:6] = waddr_b;
            clr_req  = ($urandom_range(0, 99) == 0);
            rst      = ($urandom_range(0, 599) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
